seven_segment_display_mux: RTL

Downstream display stage that consumes a packed hex number and per-digit dot bits, and drives the board's multiplexed 8-digit seven-segment display.
- Outputs: segment lines abcdefgh and one-hot digit-select lines, fed directly to the top-level uo_out / uio_out pins.
- Timing: scans one digit per refresh period.
- Tear-free: latches a whole frame of input atomically.
- Leading-zero blanking is optional.

---
 rtl/seven_segment_pkg.sv | 47 ++++
 rtl/seven_segment_decoder.sv | 15 +
 rtl/seven_segment_display_mux.sv | 111 +++++++++++
 3 files changed

// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: segment patterns (a..g, bit 6 = a) and the hex decode
// function.
package seven_segment_pkg;

  localparam int unsigned w_segments = 8;

  localparam logic [6:0] seg_0 = 7'b1111110;
  localparam logic [6:0] seg_1 = 7'b0110000;
  localparam logic [6:0] seg_2 = 7'b1101101;
  localparam logic [6:0] seg_3 = 7'b1111001;
  localparam logic [6:0] seg_4 = 7'b0110011;
  localparam logic [6:0] seg_5 = 7'b1011011;
  localparam logic [6:0] seg_6 = 7'b1011111;
  localparam logic [6:0] seg_7 = 7'b1110000;
  localparam logic [6:0] seg_8 = 7'b1111111;
  localparam logic [6:0] seg_9 = 7'b1111011;
  localparam logic [6:0] seg_a = 7'b1110111;
  localparam logic [6:0] seg_b = 7'b0011111;
  localparam logic [6:0] seg_c = 7'b1001110;
  localparam logic [6:0] seg_d = 7'b0111101;
  localparam logic [6:0] seg_e = 7'b1001111;
  localparam logic [6:0] seg_f = 7'b1000111;

  function automatic logic [6:0] hex_to_abcdefgh(input logic [3:0] nibble);
    logic [6:0] seg;
    unique case (nibble)
      4'h0: seg = seg_0;
      4'h1: seg = seg_1;
      4'h2: seg = seg_2;
      4'h3: seg = seg_3;
      4'h4: seg = seg_4;
      4'h5: seg = seg_5;
      4'h6: seg = seg_6;
      4'h7: seg = seg_7;
      4'h8: seg = seg_8;
      4'h9: seg = seg_9;
      4'ha: seg = seg_a;
      4'hb: seg = seg_b;
      4'hc: seg = seg_c;
      4'hd: seg = seg_d;
      4'he: seg = seg_e;
      4'hf: seg = seg_f;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational hex-to-segment decoder with blanking and decimal point.
module seven_segment_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0]            nibble_i,
  input  logic                  blank_i,
  input  logic                  dot_i,
  output logic [w_segments-1:0] abcdefgh_o
);

  always_comb begin
    abcdefgh_o = {(blank_i ? 7'b0 : hex_to_abcdefgh(nibble_i)), dot_i};
  end

endmodule

// File: rtl/seven_segment_display_mux.sv
// Multiplexed multi-digit seven-segment driver: scans one digit per refresh period and
// latches a whole frame of input at frame start so the display never tears.
module seven_segment_display_mux
  import seven_segment_pkg::*;
#(
  parameter int unsigned clk_mhz  = 50,
  parameter int unsigned w_digit  = 8,
  parameter int unsigned digit_hz = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*w_digit-1:0]   number,
  input  logic [w_digit-1:0]     dots,
  input  logic                   blank_lz,
  output logic [w_segments-1:0]  abcdefgh,
  output logic [w_digit-1:0]     digit
);

  localparam int unsigned Period = clk_mhz * 1_000_000 / digit_hz;
  localparam int unsigned CntW   = (Period > 1) ? $clog2(Period) : 1;
  localparam int unsigned IdxW   = (w_digit > 1) ? $clog2(w_digit) : 1;

  localparam logic [CntW-1:0] CntMax  = CntW'(Period - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(w_digit - 1);

  if (Period < 2) begin : g_bad_period
    $error("refresh period must be at least 2 clock cycles");
  end
  if (w_digit < 2) begin : g_bad_width
    $error("w_digit must be at least 2");
  end

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*w_digit-1:0]    number_q, number_d;
  logic [w_digit-1:0]      dots_q, dots_d;
  logic                    blank_lz_q, blank_lz_d;
  logic [w_segments-1:0]   abcdefgh_q, seg_next;
  logic [w_digit-1:0]      digit_q, digit_next;
  logic                    strobe, frame_start;
  logic [3:0]              nibble;
  logic                    dot, upper_nonzero, blank;

  always_comb begin
    strobe = (cnt_q == CntMax);
    cnt_d  = strobe ? '0 : cnt_q + CntW'(1);

    idx_d = idx_q;
    if (strobe) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end

    // Capture in the same cycle so digit 0 of the new frame already shows the new data.
    frame_start = strobe && (idx_d == '0);
    number_d    = frame_start ? number   : number_q;
    dots_d      = frame_start ? dots     : dots_q;
    blank_lz_d  = frame_start ? blank_lz : blank_lz_q;
  end

  always_comb begin
    nibble        = '0;
    dot           = 1'b0;
    upper_nonzero = 1'b0;
    digit_next    = '0;
    for (int i = 0; i < int'(w_digit); i++) begin
      if (IdxW'(i) == idx_d) begin
        nibble        = number_d[4*i +: 4];
        dot           = dots_d[i];
        digit_next[i] = 1'b1;
      end
      if (IdxW'(i) >= idx_d && number_d[4*i +: 4] != 4'h0) begin
        upper_nonzero = 1'b1;
      end
    end
    // Digit 0 is never blanked so a zero value still reads "0".
    blank = blank_lz_d && (idx_d != '0) && !upper_nonzero;
  end

  seven_segment_decoder u_decoder (
    .nibble_i   (nibble),
    .blank_i    (blank),
    .dot_i      (dot),
    .abcdefgh_o (seg_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= IdxLast;
      number_q   <= '0;
      dots_q     <= '0;
      blank_lz_q <= 1'b0;
      abcdefgh_q <= '0;
      digit_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      number_q   <= number_d;
      dots_q     <= dots_d;
      blank_lz_q <= blank_lz_d;
      if (strobe) begin
        abcdefgh_q <= seg_next;
        digit_q    <= digit_next;
      end
    end
  end

  assign abcdefgh = abcdefgh_q;
  assign digit    = digit_q;

endmodule
